// File: rtl/au_op_sequencer.sv
// au_op_sequencer: multicycle controller in front of the 32-bit arithmetic unit.
// Takes one ADD/SUB/MULT/DIV request at a time over valid/ready.
// ADD/SUB finish in one cycle. MULT is an unsigned shift-add multiply and DIV is an
// unsigned restoring divide, and each of those retires one bit per cycle.
// The result is held until the consumer accepts it.
// Optional build macro: AU_SEQ_EARLY_TERM_EN. When it is defined, a MULT with a zero
// operand, or a DIV with a < b, finishes in the first iteration cycle.
// Reset rst_n is asynchronous and active-high.
module au_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_zero,
  output logic             div0_err,
  output logic             busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDSUB, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d, rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
  logic             rsp_zero_q, rsp_zero_d, div0_q, div0_d;

  logic [WIDTH-1:0] addsub_s;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  logic             last_iter;

  // Single-step datapath: the add/sub result, one multiply step and one divide step.
  always_comb begin
    addsub_s = a_q + (b_q ^ {WIDTH{sub_q}}) + WIDTH'(sub_q);
    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    // The bit shifted out of rem is kept as div_rem_sh[WIDTH]. This keeps the
    // compare exact when b is at or above 2**(WIDTH-1).
    div_rem_sh = {hi_q, lo_q[WIDTH-1]};
    if (div_rem_sh >= {1'b0, b_q}) begin
      div_hi_n = div_rem_sh[WIDTH-1:0] - b_q;
      div_lo_n = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_n = div_rem_sh[WIDTH-1:0];
      div_lo_n = {lo_q[WIDTH-2:0], 1'b0};
    end
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state and next-result logic for the controller FSM.
  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the case infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_s_d     = rsp_s_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_zero_d  = rsp_zero_q;
    div0_d      = div0_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          a_d   = req_a;
          b_d   = req_b;
          sub_d = req_op[0];
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = req_a;
          if (!req_op[1]) begin
            state_d = S_ADDSUB;
          end else if (!req_op[0]) begin
            state_d = S_MUL;
          end else if (req_b != '0) begin
            state_d = S_DIV;
          end else begin
            // Divide by zero reports straight away with a zero result.
            hi_d        = '0;
            lo_d        = '0;
            rsp_s_d     = '0;
            rsp_hi_d    = '0;
            rsp_lo_d    = '0;
            rsp_zero_d  = 1'b1;
            div0_d      = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_ADDSUB: begin
        rsp_s_d     = addsub_s;
        rsp_hi_d    = '0;
        rsp_lo_d    = '0;
        rsp_zero_d  = (addsub_s == '0);
        div0_d      = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_DONE;
      end

      S_MUL: begin
`ifdef AU_SEQ_EARLY_TERM_EN
        if (cnt_q == '0 && (a_q == '0 || b_q == '0)) begin
          hi_d        = '0;
          lo_d        = '0;
          rsp_s_d     = '0;
          rsp_hi_d    = '0;
          rsp_lo_d    = '0;
          rsp_zero_d  = 1'b1;
          div0_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else
`endif
        begin
          hi_d  = mul_hi_n;
          lo_d  = mul_lo_n;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            rsp_s_d     = '0;
            rsp_hi_d    = mul_hi_n;
            rsp_lo_d    = mul_lo_n;
            rsp_zero_d  = ({mul_hi_n, mul_lo_n} == '0);
            div0_d      = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_DIV: begin
`ifdef AU_SEQ_EARLY_TERM_EN
        if (cnt_q == '0 && a_q < b_q) begin
          hi_d        = a_q;
          lo_d        = '0;
          rsp_s_d     = '0;
          rsp_hi_d    = a_q;
          rsp_lo_d    = '0;
          rsp_zero_d  = (a_q == '0);
          div0_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_DONE;
        end else
`endif
        begin
          hi_d  = div_hi_n;
          lo_d  = div_lo_n;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            rsp_s_d     = '0;
            rsp_hi_d    = div_hi_n;
            rsp_lo_d    = div_lo_n;
            rsp_zero_d  = ({div_hi_n, div_lo_n} == '0);
            div0_d      = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers. Every register, including the work registers, clears on reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_hi_q    <= '0;
      rsp_lo_q    <= '0;
      rsp_zero_q  <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the same pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_s_q     <= rsp_s_d;
      rsp_hi_q    <= rsp_hi_d;
      rsp_lo_q    <= rsp_lo_d;
      rsp_zero_q  <= rsp_zero_d;
      div0_q      <= div0_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst_n;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_lo    = rsp_lo_q;
  assign rsp_zero  = rsp_zero_q;
  assign div0_err  = div0_q;

endmodule

// File: tb/tb_au_op_sequencer.sv
// Testbench for au_op_sequencer. Randomized requests are compared against an arithmetic
// reference model. That model uses native multiply, divide and modulo, plus a latency table.
module tb_au_op_sequencer;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         zero;
    logic         div0;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_s, rsp_hi, rsp_lo;
  logic         rsp_zero, div0_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  au_op_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_zero(rsp_zero), .div0_err(div0_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the result fields come from plain integer arithmetic.
  function automatic rsp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    rsp_t r;
    logic [2*W-1:0] p;
    r = '0;
    case (op)
      2'd0: begin r.s = a + b; r.zero = (r.s == '0); end
      2'd1: begin r.s = a - b; r.zero = (r.s == '0); end
      2'd2: begin
        p = (2*W)'(a) * (2*W)'(b);
        r.hi = p[2*W-1:W];
        r.lo = p[W-1:0];
        r.zero = (p == '0);
      end
      default: begin
        if (b == '0) begin
          r.div0 = 1'b1;
          r.zero = 1'b1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
          r.zero = (r.lo == '0) && (r.hi == '0);
        end
      end
    endcase
    return r;
  endfunction

  // Expected number of cycles from the acceptance cycle to the first cycle with rsp_valid high.
  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit early;
`ifdef AU_SEQ_EARLY_TERM_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    case (op)
      2'd0, 2'd1: return 2;
      2'd2:       return (early && (a == '0 || b == '0)) ? 2 : W + 1;
      default:    return (b == '0) ? 1 : ((early && a < b) ? 2 : W + 1);
    endcase
  endfunction

  function automatic rsp_t observed();
    return {rsp_s, rsp_hi, rsp_lo, rsp_zero, div0_err};
  endfunction

  // Present a request, then count cycles until rsp_valid is seen.
  // After the accept edge, the request fields are scrambled to show that they are ignored.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit tmo);
    int w;
    w = 0; lat = 0; tmo = 1'b0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      tmo = 1'b1;
      return;
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_a = $urandom;
        req_b = $urandom;
      end
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) tmo = 1'b1;
  endtask

  // Accept the pending response. The task starts and ends at a negedge.
  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({observed(), rsp_valid, busy, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want all zero", {observed(), rsp_valid, busy, req_ready});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, want 1", req_ready);
    end
  endtask

  // Runs one request and compares both its latency and its result with the model.
  task automatic test_vectors(input string tag, input logic [1:0] op[$],
                              input logic [W-1:0] av[$], input logic [W-1:0] bv[$]);
    int lat;
    bit tmo;
    rsp_t exp;
    for (int i = 0; i < op.size(); i++) begin
      issue(op[i], av[i], bv[i], lat, tmo);
      exp = model(op[i], av[i], bv[i]);
      n_checks++;
      if (tmo || lat != model_lat(op[i], av[i], bv[i])) begin
        n_fail++;
        $display("FAIL %s_latency[%0d] op=%0d a=%h b=%h: got %0d (timeout=%0b), want %0d",
                 tag, i, op[i], av[i], bv[i], lat, tmo, model_lat(op[i], av[i], bv[i]));
      end
      n_checks++;
      if (observed() !== exp || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_result[%0d] op=%0d a=%h b=%h: got %h ready=%b, want %h ready=0",
                 tag, i, op[i], av[i], bv[i], observed(), req_ready, exp);
      end
      consume();
    end
  endtask

  task automatic test_addsub();
    logic [1:0]   op[$];
    logic [W-1:0] av[$], bv[$];
    op = '{2'd0, 2'd1, 2'd1};
    av = '{32'd5, 32'd5, 32'd0};
    bv = '{32'd7, 32'd5, 32'd1};
    for (int i = 0; i < 6; i++) begin
      op.push_back(2'($urandom_range(0, 1)));
      av.push_back($urandom);
      bv.push_back($urandom);
    end
    test_vectors("addsub", op, av, bv);
  endtask

  task automatic test_mult();
    logic [1:0]   op[$];
    logic [W-1:0] av[$], bv[$];
    op = '{2'd2};
    av = '{32'hFFFF_FFFF};
    bv = '{32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      op.push_back(2'd2);
      av.push_back($urandom);
      bv.push_back($urandom);
    end
    test_vectors("mult", op, av, bv);
  endtask

  task automatic test_div();
    logic [1:0]   op[$];
    logic [W-1:0] av[$], bv[$];
    op = '{2'd3, 2'd3, 2'd3};
    av = '{32'd100, 32'd9, 32'hFFFF_FFFF};
    bv = '{32'd7, 32'd0, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      op.push_back(2'd3);
      av.push_back($urandom);
      bv.push_back((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
    end
    test_vectors("div", op, av, bv);
  endtask

  task automatic test_early_term();
    logic [1:0]   op[$];
    logic [W-1:0] av[$], bv[$];
    op = '{2'd2, 2'd3, 2'd2};
    av = '{32'd0, 32'd3, 32'd17};
    bv = '{32'd9, 32'd8, 32'd0};
    test_vectors("early", op, av, bv);
  endtask

  // Hold off the consumer for 5 cycles while new requests are offered.
  task automatic test_backpressure();
    int lat;
    bit tmo;
    rsp_t exp;
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    exp = model(2'd1, a, b);
    issue(2'd1, a, b, lat, tmo);
    req_valid = 1'b1; req_op = 2'd2; req_a = $urandom; req_b = $urandom;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (tmo || observed() !== exp || rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %h valid=%b ready=%b busy=%b, want %h valid=1 ready=0 busy=1",
                 i, observed(), rsp_valid, req_ready, busy, exp);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    consume();
    n_checks++;
    if (observed() !== exp || rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: got %h valid=%b ready=%b busy=%b, want %h valid=0 ready=1 busy=0",
               observed(), rsp_valid, req_ready, busy, exp);
    end
  endtask

  // Pulse the reset in the middle of a multiply, then run a fresh one.
  task automatic test_reset_mid_op();
    int lat;
    bit tmo;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_op_busy: got busy=%b valid=%b, want busy=1 valid=0", busy, rsp_valid);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({observed(), rsp_valid, busy, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_op_reset: got %h, want all zero", {observed(), rsp_valid, busy, req_ready});
    end
    @(negedge clk);
    rst_n = 1'b0;
    issue(2'd2, 32'd3, 32'd4, lat, tmo);
    n_checks++;
    if (tmo || lat != W + 1 || rsp_lo !== 32'd12 || rsp_hi !== '0) begin
      n_fail++;
      $display("FAIL post_reset_mult: got lat=%0d lo=%h hi=%h, want lat=%0d lo=0000000c hi=0",
               lat, rsp_lo, rsp_hi, W + 1);
    end
    consume();
  endtask

  // Issue the next request as soon as the previous response is consumed.
  task automatic test_back_to_back();
    int lat;
    bit tmo;
    rsp_t exp;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      exp = model(2'(i % 2), a, b);
      issue(2'(i % 2), a, b, lat, tmo);
      n_checks++;
      if (tmo || lat != 2 || observed() !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got lat=%0d %h, want lat=2 %h", i, lat, observed(), exp);
      end
      consume();
      n_checks++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back_ready[%0d]: got %b, want 1", i, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mult();
    test_div();
    test_early_term();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
